// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle for mem_port_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port memory with 1-cycle read latency.
// Optional MEM_ARB_TOHOST_SNOOP_EN adds a sticky tohost write snoop.
module mem_port_arbiter #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int unsigned       STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_TOHOST_SNOOP_EN
  ,
  output logic              tohost_hit,
  output logic [DATA_W-1:0] tohost_data
`endif
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_e;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-3:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  owner_e   owner_q, owner_d;
  logic [3:0] starve_cnt, starve_nxt;
  logic     win_d, win_i, i_gnt, d_gnt;
  mem_cmd_t cmd;
  logic     unused_addr_lsb;

  assign unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    win_d = bus.d_req & (~bus.i_req | (starve_cnt < 4'(STARVE_LIMIT)));
    win_i = bus.i_req & ~win_d;
    d_gnt = win_d & bus.mem_ready & reset;
    i_gnt = win_i & bus.mem_ready & reset;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (bus.mem_ready) begin
      if (!bus.i_req || i_gnt)                 starve_nxt = '0;
      else if (starve_cnt < 4'(STARVE_LIMIT))  starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt <= '0;
    else        starve_cnt <= starve_nxt;
  end

  // Response owner FSM: state register / next state / outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (d_gnt)      owner_d = OWN_D;
    else if (i_gnt) owner_d = OWN_I;
  end

  always_comb begin
    bus.i_rvalid = (owner_q == OWN_I);
    bus.d_rvalid = (owner_q == OWN_D);
    bus.i_rdata  = (owner_q == OWN_I) ? bus.mem_rdata : '0;
    bus.d_rdata  = (owner_q == OWN_D) ? bus.mem_rdata : '0;
  end

  // Fetch is read-only and always full-word.
  always_comb begin
    if (win_d) cmd = '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr[ADDR_W-1:2], wdata: bus.d_wdata};
    else       cmd = '{we: 1'b0, be: '1, addr: bus.i_addr[ADDR_W-1:2], wdata: '0};
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_req   = (bus.i_req | bus.d_req) & bus.mem_ready & reset;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_be    = cmd.be;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;

`ifdef MEM_ARB_TOHOST_SNOOP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_hit  <= 1'b0;
      tohost_data <= '0;
    end else if (d_gnt && bus.d_we && bus.d_addr == TOHOST_ADDR && |bus.d_wdata) begin
      tohost_hit  <= 1'b1;
      tohost_data <= bus.d_wdata;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-enabled memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

`ifdef MEM_ARB_TOHOST_SNOOP_EN
  logic        tohost_hit;
  logic [31:0] tohost_data;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TOHOST_ADDR(32'h0000_1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
`ifdef MEM_ARB_TOHOST_SNOOP_EN
    ,
    .tohost_hit  (tohost_hit),
    .tohost_data (tohost_data)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mif.mem_req) begin
      if (mif.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mif.mem_be[b]) mem[mif.mem_addr[11:0]][8*b +: 8] <= mif.mem_wdata[8*b +: 8];
      end else begin
        mif.mem_rdata <= mem[mif.mem_addr[11:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    step();
    pl_we = 1'b0;
  endtask

  initial begin
    logic prev_i, exp_i;
    reset = 1'b0;
    mif.i_req = 0; mif.i_addr = '0; mif.d_req = 0; mif.d_we = 0; mif.d_be = '0;
    mif.d_addr = '0; mif.d_wdata = '0; mif.mem_ready = 1; mif.mem_rdata = '0;
    preload(12'd64, 32'hDEAD_BEEF);
    preload(12'd128, 32'hAABB_CCDD);
    preload(12'd16, 32'hCAFE_0001);

    // In reset: everything quiet even with requests pending
    mif.i_req = 1; mif.d_req = 1;
    @(negedge clk);
    chk("rst_i_gnt", mif.i_gnt, 0);
    chk("rst_d_gnt", mif.d_gnt, 0);
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_i_rvalid", mif.i_rvalid, 0);
    chk("rst_d_rvalid", mif.d_rvalid, 0);
    step();
    mif.i_req = 0; mif.d_req = 0; reset = 1'b1;
    step();

    // Single data read
    mif.d_req = 1; mif.d_addr = 32'h100;
    @(negedge clk);
    chk("rd_d_gnt", mif.d_gnt, 1);
    chk("rd_i_gnt", mif.i_gnt, 0);
    chk("rd_mem_req", mif.mem_req, 1);
    chk("rd_mem_addr", mif.mem_addr, 64);
    chk("rd_mem_we", mif.mem_we, 0);
    step();
    mif.d_req = 0;
    @(negedge clk);
    chk("rd_d_rvalid", mif.d_rvalid, 1);
    chk("rd_d_rdata", mif.d_rdata, 32'hDEAD_BEEF);
    chk("rd_i_rvalid", mif.i_rvalid, 0);
    chk("rd_i_rdata", mif.i_rdata, 0);
    step();

    // Single fetch
    mif.i_req = 1; mif.i_addr = 32'h40;
    @(negedge clk);
    chk("if_i_gnt", mif.i_gnt, 1);
    chk("if_mem_be", mif.mem_be, 4'hF);
    chk("if_mem_we", mif.mem_we, 0);
    chk("if_mem_addr", mif.mem_addr, 16);
    step();
    mif.i_req = 0;
    @(negedge clk);
    chk("if_i_rvalid", mif.i_rvalid, 1);
    chk("if_i_rdata", mif.i_rdata, 32'hCAFE_0001);
    chk("if_d_rvalid", mif.d_rvalid, 0);
    chk("if_d_rdata", mif.d_rdata, 0);
    step();

    // Contention: d x4, i x1, repeating
    mif.i_req = 1; mif.d_req = 1; mif.d_we = 0; mif.d_addr = 32'h100;
    prev_i = 0;
    for (int k = 0; k < 12; k++) begin
      exp_i = (k % 5 == 4);
      @(negedge clk);
      chk($sformatf("st%0d_i_gnt", k), mif.i_gnt, exp_i);
      chk($sformatf("st%0d_d_gnt", k), mif.d_gnt, !exp_i);
      if (k > 0) begin
        chk($sformatf("st%0d_i_rvalid", k), mif.i_rvalid, prev_i);
        chk($sformatf("st%0d_d_rvalid", k), mif.d_rvalid, !prev_i);
      end
      step();
      prev_i = exp_i;
    end

    // Stall with count at 2: nothing granted, count held
    mif.mem_ready = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_i_gnt", j), mif.i_gnt, 0);
      chk($sformatf("stall%0d_d_gnt", j), mif.d_gnt, 0);
      chk($sformatf("stall%0d_mem_req", j), mif.mem_req, 0);
      chk($sformatf("stall%0d_d_rvalid", j), mif.d_rvalid, j == 0);
      step();
    end
    mif.mem_ready = 1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      chk($sformatf("resume%0d_i_gnt", m), mif.i_gnt, m == 2);
      chk($sformatf("resume%0d_d_gnt", m), mif.d_gnt, m != 2);
      step();
    end

    // Partial write then read-back
    mif.i_req = 0; mif.d_req = 1; mif.d_we = 1; mif.d_be = 4'b0011;
    mif.d_addr = 32'h200; mif.d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_d_gnt", mif.d_gnt, 1);
    chk("wr_mem_we", mif.mem_we, 1);
    chk("wr_mem_be", mif.mem_be, 4'b0011);
    chk("wr_mem_addr", mif.mem_addr, 128);
    chk("wr_mem_wdata", mif.mem_wdata, 32'h1234_5678);
    step();
    mif.d_we = 0;
    @(negedge clk);
    chk("wr_ack", mif.d_rvalid, 1);
    chk("rb_d_gnt", mif.d_gnt, 1);
    step();
    mif.d_req = 0;
    @(negedge clk);
    chk("rb_d_rvalid", mif.d_rvalid, 1);
    chk("rb_d_rdata", mif.d_rdata, 32'hAABB_5678);
    step();

    // Reset with a response in flight and a nonzero starve count
    mif.i_req = 1; mif.d_req = 1; mif.d_addr = 32'h100;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("pre%0d_d_gnt", n), mif.d_gnt, 1);
      step();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("inrst_d_rvalid", mif.d_rvalid, 0);
    chk("inrst_d_gnt", mif.d_gnt, 0);
    chk("inrst_mem_req", mif.mem_req, 0);
    step();
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("post_d_rvalid", mif.d_rvalid, 0);
        chk("post_i_rvalid", mif.i_rvalid, 0);
      end
      chk($sformatf("post%0d_i_gnt", n), mif.i_gnt, n == 4);
      step();
    end
    mif.i_req = 0; mif.d_req = 0;
    step();

`ifdef MEM_ARB_TOHOST_SNOOP_EN
    mif.d_req = 1; mif.d_we = 1; mif.d_be = 4'hF; mif.d_addr = 32'h1000; mif.d_wdata = 32'd1;
    @(negedge clk);
    chk("th_hit0", tohost_hit, 0);
    step();
    mif.d_addr = 32'h1004; mif.d_wdata = 32'd5;
    @(negedge clk);
    chk("th_hit1", tohost_hit, 1);
    chk("th_data1", tohost_data, 1);
    step();
    mif.d_req = 0; mif.d_we = 0;
    @(negedge clk);
    chk("th_hit2", tohost_hit, 1);
    chk("th_data2", tohost_data, 1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
